sync_fifo_param: RTL and testbench
==================================

Name: sync_fifo_param

Overview:
Parametrised single-clock FIFO, the successor to the team's fixed 16-bit/8-deep FIFO. It adds:
- configurable width and depth
- selectable standard (registered-read) or first-word-fall-through (FWFT) output mode
- programmable almost-full and almost-empty flags
- sticky overflow and underflow error flags

It sits between same-clock producer/consumer pipeline stages wherever rate buffering is needed.

Parameters:
WIDTH, 16, data word width in bits (>=1)
ADDR_WIDTH, 3, log2 of depth; DEPTH = 2**ADDR_WIDTH (>=1)
FWFT, 0, 0 = standard mode (data_out registered on get); 1 = first-word-fall-through
AF_LEVEL, 6, almost_full asserted when fillcount >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 2, almost_empty asserted when fillcount <= AE_LEVEL (0..DEPTH-1)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
data_in  in  WIDTH  write data
put  in  1  write request
get  in  1  read/pop request
clear_err  in  1  clears overflow/underflow when high
data_out  out  WIDTH  read data
data_valid  out  1  standard: 1-cycle pulse, data_out updated; FWFT: head word valid (= !empty)
fillcount  out  ADDR_WIDTH+1  words stored, 0..DEPTH
empty  out  1  fillcount == 0
full  out  1  fillcount == DEPTH
almost_full  out  1  fillcount >= AF_LEVEL
almost_empty  out  1  fillcount <= AE_LEVEL
overflow  out  1  sticky: put attempted while full
underflow  out  1  sticky: get attempted while empty

Behaviour:
- Reset is checked at the clock edge and has priority over everything. Reset values:
  - wr_ptr = rd_ptr = 0, fillcount = 0
  - empty = 1, full = 0, almost_empty = 1, almost_full = (AF_LEVEL == 0 ? 1 : 0)
  - data_out = 0, data_valid = 0, overflow = 0, underflow = 0
  - Memory array is not reset.
- Pointers are ADDR_WIDTH+1 bits; memory is indexed by the low ADDR_WIDTH bits; the extra MSB disambiguates full from empty. Pointers wrap modulo 2*DEPTH.
- fillcount = wr_ptr - rd_ptr, modulo 2**(ADDR_WIDTH+1).
- All status flags are combinational from the current pointers, so they reflect state in the same cycle with no lag.
- Write accept = put && !full. The word is stored at wr_ptr and wr_ptr increments. A put while full is dropped, memory is unchanged, and overflow is set.
- Read accept = get && !empty. rd_ptr increments. A get while empty is ignored, pointers are unchanged, and underflow is set.
- Simultaneous put and get:
  - Both are accepted per the rules above; fillcount is unchanged.
  - When full, only the get is accepted and the put is an overflow.
  - When empty, only the put is accepted and the get is an underflow.
- Standard mode (FWFT = 0):
  - On an accepted get, data_out <= mem[rd_ptr] at the clock edge and data_valid = 1 for that following cycle. Read latency is 1 clock.
  - Otherwise data_out holds its value and data_valid = 0.
- FWFT mode (FWFT = 1):
  - data_out = mem[rd_ptr] combinationally and data_valid = !empty.
  - get consumes the presented word; the next word appears in the same cycle after the edge.
  - A word written into an empty FIFO is visible on data_out the cycle after the put edge (empty deasserts then).
  - When empty, data_out is don't-care.
- Sticky errors:
  - overflow and underflow stay set until clear_err or reset.
  - If clear_err and a new error event occur in the same cycle, the flag ends set (the error wins).
- Reset mid-operation: contents are discarded logically, pointers go to 0, and any in-flight data_valid pulse is cancelled.

Test Plan:
- Reset then idle (defaults WIDTH=16, ADDR_WIDTH=3) -> empty=1, full=0, fillcount=0, almost_empty=1, almost_full=0, data_out=0, errors=0.
- Standard mode: put 0x1111..0x8888 on 8 consecutive cycles -> fillcount=8, full=1, almost_full asserts at fillcount=6. Then 8 gets -> data_out 0x1111..0x8888, each one cycle after its get with data_valid=1. Empty returns, fillcount=0.
- Full FIFO plus put 0xDEAD -> overflow=1, contents unchanged. Subsequent reads show no 0xDEAD. clear_err -> overflow=0. get on empty -> underflow=1, pointers unchanged.
- Simultaneous put+get at fillcount=4 for 20 cycles with an incrementing pattern -> fillcount stays 4, data ordered correctly across pointer wrap. Simultaneous put+get when full -> get accepted, put flagged overflow, fillcount=7.
- FWFT=1: put 0xA5A5 into empty -> next cycle data_out=0xA5A5, data_valid=1. get with no put -> data_valid=0 the next cycle.
- Assert reset while fillcount=5 and a standard-mode get is pending -> next cycle fillcount=0, empty=1, data_valid=0, data_out=0. clear_err and an overflow-causing put in the same cycle -> overflow=1.

Source files
------------

// File: rtl/sync_fifo_param.sv
`default_nettype none
// ============================================================================
// sync_fifo_param : single-clock FIFO, configurable size, standard or FWFT read
// Revision 1.0
// ============================================================================
module sync_fifo_param #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 3,
  parameter int FWFT       = 0,
  parameter int AF_LEVEL   = 6,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      i_data_in,
  input  logic                  i_put,
  input  logic                  i_get,
  input  logic                  i_clear_err,
  output logic [WIDTH-1:0]      o_data_out,
  output logic                  o_data_valid,
  output logic [ADDR_WIDTH:0]   o_fillcount,
  output logic                  o_empty,
  output logic                  o_full,
  output logic                  o_almost_full,
  output logic                  o_almost_empty,
  output logic                  o_overflow,
  output logic                  o_underflow
);

  localparam int                 DEPTH   = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] C_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] C_AF    = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] C_AE    = (ADDR_WIDTH+1)'(AE_LEVEL);

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [ADDR_WIDTH:0]   r_wr_ptr;
  logic [ADDR_WIDTH:0]   r_rd_ptr;
  logic                  r_overflow;
  logic                  r_underflow;

  logic [ADDR_WIDTH:0]   w_count;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_wr_accept;
  logic                  w_rd_accept;
  logic [ADDR_WIDTH-1:0] w_wr_idx;
  logic [ADDR_WIDTH-1:0] w_rd_idx;

  // Extra pointer MSB makes wr-rd distinguish a full FIFO from an empty one.
  assign w_count     = r_wr_ptr - r_rd_ptr;
  assign w_empty     = (w_count == '0);
  assign w_full      = (w_count == C_DEPTH);
  assign w_wr_accept = i_put && !w_full;
  assign w_rd_accept = i_get && !w_empty;
  assign w_wr_idx    = r_wr_ptr[ADDR_WIDTH-1:0];
  assign w_rd_idx    = r_rd_ptr[ADDR_WIDTH-1:0];

  assign o_fillcount    = w_count;
  assign o_empty        = w_empty;
  assign o_full         = w_full;
  assign o_almost_full  = (w_count >= C_AF);
  assign o_almost_empty = (w_count <= C_AE);
  assign o_overflow     = r_overflow;
  assign o_underflow    = r_underflow;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_accept) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd_accept) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_wr_accept) begin
      r_mem[w_wr_idx] <= i_data_in;
    end
  end

  // A new error in the same cycle as clear_err leaves the flag set.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (i_put && w_full) begin
        r_overflow <= 1'b1;
      end else if (i_clear_err) begin
        r_overflow <= 1'b0;
      end
      if (i_get && w_empty) begin
        r_underflow <= 1'b1;
      end else if (i_clear_err) begin
        r_underflow <= 1'b0;
      end
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign o_data_out   = r_mem[w_rd_idx];
      assign o_data_valid = !w_empty;
    end else begin : g_std
      logic [WIDTH-1:0] r_data_out;
      logic             r_data_valid;

      always_ff @(posedge clk) begin
        if (reset) begin
          r_data_out   <= '0;
          r_data_valid <= 1'b0;
        end else begin
          r_data_valid <= w_rd_accept;
          if (w_rd_accept) begin
            r_data_out <= r_mem[w_rd_idx];
          end
        end
      end

      assign o_data_out   = r_data_out;
      assign o_data_valid = r_data_valid;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
`default_nettype none
// ============================================================================
// tb_sync_fifo_param : checks standard and FWFT instances against a queue model
// Revision 1.0
// ============================================================================
module tb_sync_fifo_param;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] din = '0;
  logic        put = 1'b0;
  logic        get = 1'b0;
  logic        clr = 1'b0;

  logic [15:0] s_dout, f_dout;
  logic        s_dv, f_dv;
  logic [3:0]  s_fill, f_fill;
  logic        s_empty, s_full, s_af, s_ae, s_ov, s_un;
  logic        f_empty, f_full, f_af, f_ae, f_ov, f_un;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sync_fifo_param #(.WIDTH(16), .ADDR_WIDTH(3), .FWFT(0), .AF_LEVEL(6), .AE_LEVEL(2)) u_std (
    .clk(clk), .reset(reset), .i_data_in(din), .i_put(put), .i_get(get), .i_clear_err(clr),
    .o_data_out(s_dout), .o_data_valid(s_dv), .o_fillcount(s_fill), .o_empty(s_empty),
    .o_full(s_full), .o_almost_full(s_af), .o_almost_empty(s_ae),
    .o_overflow(s_ov), .o_underflow(s_un)
  );

  sync_fifo_param #(.WIDTH(16), .ADDR_WIDTH(3), .FWFT(1), .AF_LEVEL(6), .AE_LEVEL(2)) u_fwft (
    .clk(clk), .reset(reset), .i_data_in(din), .i_put(put), .i_get(get), .i_clear_err(clr),
    .o_data_out(f_dout), .o_data_valid(f_dv), .o_fillcount(f_fill), .o_empty(f_empty),
    .o_full(f_full), .o_almost_full(f_af), .o_almost_empty(f_ae),
    .o_overflow(f_ov), .o_underflow(f_un)
  );

  // Reference model: a queue of stored words plus the error and read-port state.
  logic [15:0] mq[$];
  logic [15:0] m_dout = '0;
  bit          m_dv = 1'b0;
  bit          m_ov = 1'b0;
  bit          m_un = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%0h want=%0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_update();
    bit was_full;
    bit was_empty;
    if (reset) begin
      mq.delete();
      m_dout = '0;
      m_dv   = 1'b0;
      m_ov   = 1'b0;
      m_un   = 1'b0;
    end else begin
      was_full  = (mq.size() == 8);
      was_empty = (mq.size() == 0);
      if (get && !was_empty) begin
        m_dout = mq.pop_front();
        m_dv   = 1'b1;
      end else begin
        m_dv = 1'b0;
      end
      if (put && !was_full) mq.push_back(din);
      if (put && was_full) m_ov = 1'b1;
      else if (clr)        m_ov = 1'b0;
      if (get && was_empty) m_un = 1'b1;
      else if (clr)         m_un = 1'b0;
    end
  endtask

  task automatic check_all();
    int n;
    n = mq.size();
    chk("s_fill", s_fill, n);
    chk("s_empty", s_empty, n == 0);
    chk("s_full", s_full, n == 8);
    chk("s_afull", s_af, n >= 6);
    chk("s_aempty", s_ae, n <= 2);
    chk("s_ovf", s_ov, m_ov);
    chk("s_unf", s_un, m_un);
    chk("s_valid", s_dv, m_dv);
    chk("s_dout", s_dout, m_dout);
    chk("f_fill", f_fill, n);
    chk("f_empty", f_empty, n == 0);
    chk("f_full", f_full, n == 8);
    chk("f_afull", f_af, n >= 6);
    chk("f_aempty", f_ae, n <= 2);
    chk("f_ovf", f_ov, m_ov);
    chk("f_unf", f_un, m_un);
    chk("f_valid", f_dv, n != 0);
    if (n != 0) chk("f_dout", f_dout, mq[0]);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  task automatic cyc(input bit r, input bit p, input bit g, input bit c, input logic [15:0] d);
    reset = r; put = p; get = g; clr = c; din = d;
    step();
  endtask

  typedef struct {
    bit          rst, p, g, c;
    logic [15:0] d;
    int          fill;
    logic [15:0] dout;
    bit          dv, ov, un;
  } vec_t;

  vec_t tbl[14];

  initial begin
    tbl[0] = '{1, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0};
    for (int i = 1; i <= 8; i++)
      tbl[i] = '{0, 1, 0, 0, 16'(16'h1111 * i), i, 16'h0000, 0, 0, 0};
    tbl[9]  = '{0, 1, 0, 0, 16'hDEAD, 8, 16'h0000, 0, 1, 0};
    tbl[10] = '{0, 0, 0, 1, 16'h0000, 8, 16'h0000, 0, 0, 0};
    tbl[11] = '{0, 0, 1, 0, 16'h0000, 7, 16'h1111, 1, 0, 0};
    tbl[12] = '{0, 0, 1, 0, 16'h0000, 6, 16'h2222, 1, 0, 0};
    tbl[13] = '{0, 0, 0, 0, 16'h0000, 6, 16'h2222, 0, 0, 0};

    for (int i = 0; i < 14; i++) begin
      cyc(tbl[i].rst, tbl[i].p, tbl[i].g, tbl[i].c, tbl[i].d);
      chk("t_fill", s_fill, tbl[i].fill);
      chk("t_full", s_full, tbl[i].fill == 8);
      chk("t_afull", s_af, tbl[i].fill >= 6);
      chk("t_dout", s_dout, tbl[i].dout);
      chk("t_valid", s_dv, tbl[i].dv);
      chk("t_ovf", s_ov, tbl[i].ov);
      chk("t_unf", s_un, tbl[i].un);
    end

    // Drain the rest (no 0xDEAD may appear), then underflow on empty.
    for (int i = 3; i <= 8; i++) begin
      cyc(0, 0, 1, 0, '0);
      chk("drain_dout", s_dout, 16'(16'h1111 * i));
    end
    cyc(0, 0, 1, 0, '0);
    chk("unf_set", s_un, 1'b1);
    chk("unf_fill", s_fill, 0);
    cyc(0, 0, 0, 1, '0);
    chk("unf_clr", s_un, 1'b0);

    // Steady state at fill 4 with simultaneous put/get across pointer wrap.
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 16'(16'h0100 + i));
    for (int i = 0; i < 20; i++) begin
      cyc(0, 1, 1, 0, 16'(16'h0200 + i));
      chk("pg_fill", s_fill, 4);
    end

    // Put+get while full: get accepted, put is an overflow.
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 16'(16'h0300 + i));
    chk("full_before", s_full, 1'b1);
    cyc(0, 1, 1, 0, 16'hBEEF);
    chk("pgfull_fill", s_fill, 7);
    chk("pgfull_ovf", s_ov, 1'b1);
    chk("pgfull_dv", s_dv, 1'b1);
    cyc(0, 0, 0, 1, '0);
    cyc(0, 1, 0, 0, 16'h0400);
    cyc(0, 1, 0, 1, 16'h0401);
    chk("clr_vs_ovf", s_ov, 1'b1);

    // Reset while a read is requested cancels the pending pulse.
    cyc(1, 0, 0, 0, '0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 16'(16'h0500 + i));
    chk("pre_rst_fill", s_fill, 5);
    cyc(1, 0, 1, 0, '0);
    chk("rst_fill", s_fill, 0);
    chk("rst_empty", s_empty, 1'b1);
    chk("rst_dv", s_dv, 1'b0);
    chk("rst_dout", s_dout, 16'h0000);

    // FWFT: word appears the cycle after the put edge.
    cyc(0, 1, 0, 0, 16'hA5A5);
    chk("fwft_dout", f_dout, 16'hA5A5);
    chk("fwft_dv", f_dv, 1'b1);
    cyc(0, 0, 1, 0, '0);
    chk("fwft_dv_off", f_dv, 1'b0);

    // Randomised traffic checked against the model.
    for (int i = 0; i < 800; i++) begin
      cyc(($urandom % 100) == 0, ($urandom % 3) != 0, ($urandom % 2) == 0,
          ($urandom % 16) == 0, 16'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
